// File: rtl/spi_flash_read_seq_if.sv
// Request and read-data channels of the SPI flash read sequencer.
interface spi_flash_read_seq_if #(
    parameter int LEN_W = 8
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [23:0]      req_addr_i;
    logic [LEN_W-1:0] req_len_i;
    logic             rd_valid_o;
    logic             rd_ready_i;
    logic [7:0]       rd_data_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_len_i, rd_ready_i,
        output req_ready_o, rd_valid_o, rd_data_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_len_i, rd_ready_i,
        input  req_ready_o, rd_valid_o, rd_data_o
    );
endinterface

// File: rtl/spi_flash_read_seq.sv
// Flash read transaction sequencer driving the SPI byte engine.
// Owns chip-select and streams read bytes through a valid/ready port.
module spi_flash_read_seq #(
    parameter logic [7:0] CMD_OPCODE  = 8'h03,
    parameter int         DUMMY_BYTES = 0,
    parameter int         LEN_W       = 8,
    parameter int         CS_GAP      = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    spi_flash_read_seq_if.slave  bus,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 eng_start_o,
    output logic [7:0]           eng_tx_byte_o,
    input  logic [7:0]           eng_rx_byte_i,
    input  logic                 eng_byte_done_i,
    output logic                 spi_csb_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_CS_SETUP, S_CMD, S_ADDR,
        S_DUMMY, S_DATA, S_CS_HOLD, S_GAP
    } state_t;

    localparam int GW = $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(CS_GAP);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

    state_t           r_state;
    state_t           w_next;
    logic [23:0]      r_addr;
    logic [LEN_W-1:0] r_remain;
    logic [2:0]       r_idx;
    logic             r_wait;
    logic             r_rd_valid;
    logic [7:0]       r_rd_data;
    logic             r_csb;
    logic [GW-1:0]    r_gap_cnt;
    logic             r_out_en;

    logic       w_accept;
    logic       w_byte_done;
    logic       w_pop;
    logic       w_req_ready;
    logic       w_start;
    logic [7:0] w_tx_byte;
    logic [7:0] w_addr_byte;
    logic       w_done;
    logic       w_busy;

    assign w_accept    = bus.req_valid_i && w_req_ready;
    assign w_byte_done = r_wait && eng_byte_done_i;
    assign w_pop       = r_rd_valid && bus.rd_ready_i;
    assign w_addr_byte = (r_idx[1:0] == 2'd0) ? r_addr[23:16] :
                         (r_idx[1:0] == 2'd1) ? r_addr[15:8]  :
                                                r_addr[7:0];

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:
                if (w_accept)
                    w_next = (bus.req_len_i == '0) ? S_GAP : S_CS_SETUP;
            S_CS_SETUP: w_next = S_CMD;
            S_CMD:
                if (w_byte_done) w_next = S_ADDR;
            S_ADDR:
                if (w_byte_done && r_idx == 3'd2)
                    w_next = (DUMMY_BYTES == 0) ? S_DATA : S_DUMMY;
            S_DUMMY:
                if (w_byte_done && r_idx == 3'(DUMMY_BYTES - 1))
                    w_next = S_DATA;
            S_DATA:
                if (w_byte_done && r_remain == LEN_W'(1))
                    w_next = S_CS_HOLD;
            S_CS_HOLD: w_next = S_GAP;
            S_GAP:
                // the last byte must be popped before a new request is taken
                if (r_gap_cnt >= GAP_LAST && !r_rd_valid)
                    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_ready = 1'b0;
        w_start     = 1'b0;
        w_tx_byte   = 8'h00;
        w_done      = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_req_ready = r_out_en;
                w_busy      = 1'b0;
            end
            S_CMD: begin
                w_start   = !r_wait;
                w_tx_byte = CMD_OPCODE;
            end
            S_ADDR: begin
                w_start   = !r_wait;
                w_tx_byte = w_addr_byte;
            end
            S_DUMMY: w_start = !r_wait;
            S_DATA:  w_start = !r_wait && (!r_rd_valid || bus.rd_ready_i);
            S_GAP: begin
                w_done = (r_gap_cnt == '0);
                w_busy = w_done;
            end
            default: w_busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_remain   <= '0;
            r_idx      <= '0;
            r_wait     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_csb      <= 1'b1;
            r_gap_cnt  <= '0;
            r_out_en   <= 1'b0;
        end else begin
            r_out_en <= 1'b1;
            r_csb    <= !(w_next inside {S_CS_SETUP, S_CMD, S_ADDR,
                                         S_DUMMY, S_DATA, S_CS_HOLD});
            if (w_accept) begin
                r_addr   <= bus.req_addr_i;
                r_remain <= bus.req_len_i;
            end
            if (w_start) r_wait <= 1'b1;
            if (w_byte_done) begin
                r_wait <= 1'b0;
                r_idx  <= (w_next != r_state) ? 3'd0 : r_idx + 3'd1;
                if (r_state == S_DATA) begin
                    r_rd_data <= eng_rx_byte_i;
                    r_remain  <= r_remain - LEN_W'(1);
                end
            end
            if (w_byte_done && r_state == S_DATA) r_rd_valid <= 1'b1;
            else if (w_pop)                         r_rd_valid <= 1'b0;
            if (r_state == S_GAP) begin
                if (r_gap_cnt != GAP_MAX) r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= '0;
            end
        end
    end

    assign bus.req_ready_o = w_req_ready;
    assign bus.rd_valid_o  = r_rd_valid;
    assign bus.rd_data_o   = r_rd_data;
    assign done_o          = w_done;
    assign busy_o          = w_busy;
    assign eng_start_o     = w_start;
    assign eng_tx_byte_o   = w_tx_byte;
    assign spi_csb_o       = r_csb;
endmodule

// File: doc/spi_flash_read_seq.md
Name: spi_flash_read_seq

Overview:
- Transaction sequencer sitting above the housekeeping SPI byte engine.
- Accepts a read request (24-bit address, byte count) and drives the byte engine through one flash transaction: opcode, 3 address bytes MSB first, optional dummy bytes, then N read bytes.
- Owns chip-select for the whole transaction and streams read bytes out through a valid/ready port with backpressure.

Parameters:
- CMD_OPCODE, 8'h03, read opcode sent as the first byte.
- DUMMY_BYTES, 0, number of 8'h00 bytes sent between address and data (0..7).
- LEN_W, 8, width of the request byte count.
- CS_GAP, 2, minimum clk cycles CSB stays high between transactions (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  24  flash start address.
- req_len_i  in  LEN_W  number of data bytes to read; 0 = no bus activity.
- rd_valid_o  out  1  read byte available.
- rd_ready_i  in  1  consumer accepts byte.
- rd_data_o  out  8  read byte.
- done_o  out  1  one-cycle pulse at transaction end.
- busy_o  out  1  high from accept until done_o inclusive.
- eng_start_o  out  1  one-cycle start pulse to byte engine.
- eng_tx_byte_o  out  8  byte to transmit; stable from start until eng_byte_done_i.
- eng_rx_byte_i  in  8  received byte, valid in the eng_byte_done_i cycle.
- eng_byte_done_i  in  1  byte engine completion pulse.
- spi_csb_o  out  1  flash chip select, active low.

Behaviour:
- Reset values: req_ready_o=0 for the reset cycle, then 1 in IDLE. rd_valid_o=0, rd_data_o=0, done_o=0, busy_o=0, eng_start_o=0, eng_tx_byte_o=0, spi_csb_o=1. All internal counters cleared; state IDLE.
- States: IDLE -> CS_SETUP -> CMD -> ADDR -> DUMMY -> DATA -> CS_HOLD -> GAP -> IDLE.
  - DUMMY is skipped when DUMMY_BYTES=0.
- IDLE:
  - req_ready_o=1.
  - On accept, latch addr/len and set busy_o next cycle.
  - If len=0: go directly to GAP with done_o pulsed on the following cycle; CSB never falls.
  - Otherwise go to CS_SETUP.
- CS_SETUP: spi_csb_o=0 for one cycle before the first start pulse.
- Byte phases (CMD, ADDR, DUMMY, DATA):
  - On phase entry, or after the previous eng_byte_done_i, pulse eng_start_o for exactly one cycle with eng_tx_byte_o set.
  - Then wait for eng_byte_done_i. eng_byte_done_i while not waiting is ignored.
- CMD sends CMD_OPCODE.
- ADDR sends addr[23:16], [15:8], [7:0] using a 2-bit byte index.
- DUMMY sends 8'h00 DUMMY_BYTES times.
- DATA:
  - Sends 8'h00. On eng_byte_done_i, capture eng_rx_byte_i into rd_data_o; rd_valid_o rises the next cycle.
  - rd_valid_o/rd_data_o stay stable until rd_valid_o&rd_ready_i.
  - Next eng_start_o is issued only when the output register is empty or being popped in the same cycle. CSB stays low while stalled.
  - Remaining-count decrements per captured byte (LEN_W bits, no wrap). Leave DATA after the last byte is captured.
- CS_HOLD: one cycle with CSB low after the last done, then CSB=1.
- GAP:
  - CSB high for CS_GAP cycles; done_o pulses in the first GAP cycle; busy_o falls after it.
  - req_ready_o=0 throughout GAP. The last read byte may still be pending on rd_valid_o.
- IDLE is not re-entered while rd_valid_o=1. New requests wait until the final byte is popped.
- spi_csb_o is registered and glitch-free. It is low only between CS_SETUP and CS_HOLD inclusive.
- Reset mid-transaction: next cycle CSB=1, rd_valid_o=0, state IDLE. No done_o.

Test Plan:
- Reset, then idle 10 cycles -> spi_csb_o=1, req_ready_o=1, all other outputs 0, no eng_start_o.
- Request addr=24'h12_34_56, len=4, engine model returns A0..A3, rd_ready_i=1 -> eng_tx_byte_o sequence 03,12,34,56,00,00,00,00; rd_data_o sequence A0,A1,A2,A3; CSB low across all 8 bytes; done_o once; exactly 8 start pulses.
- DUMMY_BYTES=1, len=1 -> tx sequence 03,aa,bb,cc,00,00; only the 6th byte's rx appears on rd_data_o.
- len=3, rd_ready_i held low 20 cycles after the first byte -> no eng_start_o during stall; rd_data_o stable; CSB stays 0; after release the remaining 2 bytes complete.
- len=0 -> CSB never falls, no eng_start_o, done_o pulses once, back-to-back request accepted after CS_GAP cycles.
- reset_n low during ADDR byte 2 -> CSB=1 next cycle, rd_valid_o=0, no done_o; a new len=1 request afterwards completes normally.
